multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the MIPS-subset datapath. It replaces the single-cycle decode with a 5-state FSM (IF, ID, EX, MEM, WB). The FSM time-shares one memory port between instruction fetch and data access through a req/ready handshake. It drives per-cycle enables for PC, IR, register file and memory, plus ALU configuration using the existing ALUC encoding.

Parameters:
ALUC_W, 4, ALU control width
OP_W, 6, opcode/func field width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
op  in  6  IR[31:26], valid from ID onward
func  in  6  IR[5:0]
Z  in  1  ALU zero/compare flag, valid in EX
MEM_READY  in  1  memory accepts/completes current access
MEM_REQ  out  1  memory access request
IORD  out  1  0 = PC addresses memory, 1 = ALU result addresses memory
IRWRITE  out  1  load IR from memory read data
PCWRITE  out  1  load PC (PC+4, branch target or jump target per BRANCH/JUMP)
WMEM  out  1  write data memory (qualifies MEM_REQ)
M2REG  out  1  writeback source: 1 = memory data, 0 = ALU result
WREG  out  1  register-file write enable
REGRT  out  1  destination register: 1 = rt, 0 = rd
ALUIMM  out  1  ALU B input: 1 = extended immediate
SEXT  out  1  sign-extend immediate
ALUC  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt, 0101 bne-compare, 0110 beq-compare, 1111 nop
BRANCH  out  1  select branch target for PCWRITE
JUMP  out  1  select jump target for PCWRITE
ILLEGAL  out  1  one-cycle pulse on an undecodable op/func

Behaviour:
- Reset (sync, rst high at posedge): state <= IF. All outputs are combinational from state and op/func/Z. While rst is high they are forced to 0, except ALUC = 0000. Reset asserted mid-access drops MEM_REQ in the next cycle with no PC, IR, register or memory side effect.
- IF:
  - MEM_REQ = 1, IORD = 0; hold until MEM_READY = 1 is sampled.
  - In the MEM_READY cycle: IRWRITE = 1, PCWRITE = 1 (PC+4, BRANCH = JUMP = 0), then go to ID.
  - MEM_READY sampled while MEM_REQ = 0 is ignored.
- ID: decode op/func.
  - j (000010): PCWRITE = 1, JUMP = 1, go to IF.
  - nop (op = 0, func = 0): go to IF, no writes.
  - illegal: ILLEGAL = 1 for one cycle, go to IF, no writes.
  - Otherwise: go to EX.
- EX: ALUC, ALUIMM and SEXT are driven as in the single-cycle decode (see per-class lines below). REGRT is driven here and held through WB.
  - R-type add/sub/and/or/slt: ALUIMM = 0, go to WB.
  - addi/andi/ori/slti: ALUIMM = 1, SEXT = 1, go to WB.
  - lw/sw: ALUC = 0000, ALUIMM = 1, SEXT = 1, go to MEM.
  - beq/bne: ALUC = 0110 (beq) or 0101 (bne). If Z = 1: PCWRITE = 1, BRANCH = 1. Go to IF.
- MEM:
  - MEM_REQ = 1, IORD = 1, WMEM = 1 for sw; hold until MEM_READY.
  - sw: on READY go to IF.
  - lw: on READY go to WB (read data is latched by the datapath MDR in that cycle).
- WB: WREG = 1 for exactly one cycle, REGRT = 1 for I-type/lw, M2REG = 1 for lw. Go to IF.
- Latency with zero-wait memory: j/nop = 2 cycles, beq/bne = 3, ALU ops and sw = 4, lw = 5. Each wait cycle on MEM_READY adds 1.
- No output is asserted outside its stated state. PCWRITE, IRWRITE and WREG never assert more than once per instruction.
- op/func are sampled only in ID, EX, MEM and WB. A changing IR during IF is ignored.

Optional Feature:
PERF_CNT_EN
- Defined:
  - Adds outputs CYC_CNT[31:0] and RET_CNT[31:0], both cleared by rst.
  - CYC_CNT increments every cycle when not in reset.
  - RET_CNT increments on the cycle the FSM returns to IF after a legal instruction. ILLEGAL does not count.
  - Both counters wrap from 0xFFFFFFFF to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mcpu_pkg:
  - State enum: IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4.
  - Opcode constants: R = 000000, ADDI = 001000, ANDI = 001100, ORI = 001101, SLTI = 001010, LW = 100011, SW = 101011, J = 000010, BEQ = 000100, BNE = 000101.
  - Func constants: ADD = 100000, SUB = 100010, AND = 100100, OR = 100101, SLT = 101010, NOP = 000000.
  - ALUC constants.
- Sub-module mcpu_decode: purely combinational op/func to instruction class, ALUC, ALUIMM, SEXT, REGRT, plus an illegal flag. The FSM and output gating stay in multicycle_ctrl.

Test Plan:
- rst high 2 cycles, then low, MEM_READY = 1 -> cycle 0 IF: MEM_REQ = 1, IORD = 0, IRWRITE = PCWRITE = 1; all outputs 0 during reset.
- add (op 000000, func 100000), MEM_READY = 1 -> IF, ID, EX (ALUC = 0000, ALUIMM = 0), WB (WREG = 1, REGRT = 0, M2REG = 0); back to IF at cycle 4.
- lw (100011) with MEM_READY low for 3 cycles in MEM -> MEM_REQ = 1, IORD = 1 held 4 cycles; WB has WREG = 1, M2REG = 1, REGRT = 1; total 8 cycles.
- beq (000100) with Z = 1 -> EX: ALUC = 0110, PCWRITE = 1, BRANCH = 1, then IF. Same instruction with Z = 0 -> PCWRITE = 0 in EX. bne (000101) with Z = 1 -> ALUC = 0101, BRANCH = 1.
- j (000010) -> ID: PCWRITE = 1, JUMP = 1, then IF; op 111111 -> ILLEGAL pulse 1 cycle, no WREG/WMEM.
- sw (101011), rst asserted during MEM with MEM_READY = 0 -> next cycle MEM_REQ = 0, WMEM = 0, state IF. With PERF_CNT_EN: after 3 addi instructions at zero-wait, RET_CNT = 3 and CYC_CNT = 12.

Source files
------------

// File: rtl/mcpu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset controller.
package mcpu_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP   = 4'd0,
        CLS_ALU_R = 4'd1,
        CLS_ALU_I = 4'd2,
        CLS_LW    = 4'd3,
        CLS_SW    = 4'd4,
        CLS_BEQ   = 4'd5,
        CLS_BNE   = 4'd6,
        CLS_J     = 4'd7,
        CLS_ILL   = 4'd8
    } iclass_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOP = 6'b000000;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0001;
    localparam logic [3:0] ALUC_AND = 4'b0010;
    localparam logic [3:0] ALUC_OR  = 4'b0011;
    localparam logic [3:0] ALUC_SLT = 4'b0100;
    localparam logic [3:0] ALUC_BNE = 4'b0101;
    localparam logic [3:0] ALUC_BEQ = 4'b0110;
    localparam logic [3:0] ALUC_NOP = 4'b1111;

endpackage

// File: rtl/mcpu_decode.sv
// Combinational op/func decode into instruction class and ALU configuration.
module mcpu_decode
    import mcpu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output iclass_t    iclass,
    output logic [3:0] aluc,
    output logic       aluimm,
    output logic       sext,
    output logic       regrt,
    output logic       illegal
);

    // Opcode/function decode; anything unlisted falls to the illegal class.
    always_comb begin
        iclass = CLS_ILL;
        aluc   = ALUC_NOP;
        aluimm = 1'b0;
        sext   = 1'b0;
        regrt  = 1'b0;
        case (op)
            OP_R: begin
                case (func)
                    FN_ADD: begin iclass = CLS_ALU_R; aluc = ALUC_ADD; end
                    FN_SUB: begin iclass = CLS_ALU_R; aluc = ALUC_SUB; end
                    FN_AND: begin iclass = CLS_ALU_R; aluc = ALUC_AND; end
                    FN_OR:  begin iclass = CLS_ALU_R; aluc = ALUC_OR;  end
                    FN_SLT: begin iclass = CLS_ALU_R; aluc = ALUC_SLT; end
                    FN_NOP: begin iclass = CLS_NOP; end
                    default: begin iclass = CLS_ILL; end
                endcase
            end
            OP_ADDI: begin
                iclass = CLS_ALU_I; aluc = ALUC_ADD;
                aluimm = 1'b1; sext = 1'b1; regrt = 1'b1;
            end
            OP_ANDI: begin
                iclass = CLS_ALU_I; aluc = ALUC_AND;
                aluimm = 1'b1; sext = 1'b1; regrt = 1'b1;
            end
            OP_ORI: begin
                iclass = CLS_ALU_I; aluc = ALUC_OR;
                aluimm = 1'b1; sext = 1'b1; regrt = 1'b1;
            end
            OP_SLTI: begin
                iclass = CLS_ALU_I; aluc = ALUC_SLT;
                aluimm = 1'b1; sext = 1'b1; regrt = 1'b1;
            end
            OP_LW: begin
                iclass = CLS_LW; aluc = ALUC_ADD;
                aluimm = 1'b1; sext = 1'b1; regrt = 1'b1;
            end
            OP_SW: begin
                iclass = CLS_SW; aluc = ALUC_ADD;
                aluimm = 1'b1; sext = 1'b1; regrt = 1'b1;
            end
            OP_BEQ:  begin iclass = CLS_BEQ; aluc = ALUC_BEQ; end
            OP_BNE:  begin iclass = CLS_BNE; aluc = ALUC_BNE; end
            OP_J:    begin iclass = CLS_J; end
            default: begin iclass = CLS_ILL; end
        endcase
    end

    assign illegal = (iclass == CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Five-state multi-cycle sequencer sharing one memory port between fetch and data.
// Optional performance counters are built when PERF_CNT_EN is defined.
module multicycle_ctrl
    import mcpu_pkg::*;
#(
    parameter int ALUC_W = 4,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   op,
    input  logic [OP_W-1:0]   func,
    input  logic              Z,
    input  logic              MEM_READY,
    output logic              MEM_REQ,
    output logic              IORD,
    output logic              IRWRITE,
    output logic              PCWRITE,
    output logic              WMEM,
    output logic              M2REG,
    output logic              WREG,
    output logic              REGRT,
    output logic              ALUIMM,
    output logic              SEXT,
    output logic [ALUC_W-1:0] ALUC,
    output logic              BRANCH,
    output logic              JUMP,
`ifdef PERF_CNT_EN
    output logic [31:0]       CYC_CNT,
    output logic [31:0]       RET_CNT,
`endif
    output logic              ILLEGAL
);

    state_t     state_r;
    state_t     state_next_s;
    iclass_t    dec_class_s;
    logic [3:0] dec_aluc_s;
    logic       dec_aluimm_s;
    logic       dec_sext_s;
    logic       dec_regrt_s;
    logic       dec_illegal_s;

    mcpu_decode u_decode (
        .op      (op),
        .func    (func),
        .iclass  (dec_class_s),
        .aluc    (dec_aluc_s),
        .aluimm  (dec_aluimm_s),
        .sext    (dec_sext_s),
        .regrt   (dec_regrt_s),
        .illegal (dec_illegal_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IF;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-state control outputs; reset masks everything but ALUC=add.
    always_comb begin
        state_next_s = state_r;
        MEM_REQ = 1'b0;
        IORD    = 1'b0;
        IRWRITE = 1'b0;
        PCWRITE = 1'b0;
        WMEM    = 1'b0;
        M2REG   = 1'b0;
        WREG    = 1'b0;
        REGRT   = 1'b0;
        ALUIMM  = 1'b0;
        SEXT    = 1'b0;
        ALUC    = ALUC_NOP;
        BRANCH  = 1'b0;
        JUMP    = 1'b0;
        ILLEGAL = 1'b0;
        if (rst) begin
            state_next_s = ST_IF;
            ALUC         = ALUC_ADD;
        end else begin
            case (state_r)
                ST_IF: begin
                    MEM_REQ = 1'b1;
                    IORD    = 1'b0;
                    if (MEM_READY) begin
                        IRWRITE      = 1'b1;
                        PCWRITE      = 1'b1;
                        state_next_s = ST_ID;
                    end else begin
                        state_next_s = ST_IF;
                    end
                end
                ST_ID: begin
                    case (dec_class_s)
                        CLS_J: begin
                            PCWRITE      = 1'b1;
                            JUMP         = 1'b1;
                            state_next_s = ST_IF;
                        end
                        CLS_NOP: state_next_s = ST_IF;
                        CLS_ILL: begin
                            ILLEGAL      = dec_illegal_s;
                            state_next_s = ST_IF;
                        end
                        default: state_next_s = ST_EX;
                    endcase
                end
                ST_EX: begin
                    ALUC   = dec_aluc_s;
                    ALUIMM = dec_aluimm_s;
                    SEXT   = dec_sext_s;
                    REGRT  = dec_regrt_s;
                    case (dec_class_s)
                        CLS_ALU_R, CLS_ALU_I: state_next_s = ST_WB;
                        CLS_LW, CLS_SW:       state_next_s = ST_MEM;
                        CLS_BEQ, CLS_BNE: begin
                            if (Z) begin
                                PCWRITE = 1'b1;
                                BRANCH  = 1'b1;
                            end else begin
                                PCWRITE = 1'b0;
                                BRANCH  = 1'b0;
                            end
                            state_next_s = ST_IF;
                        end
                        default: state_next_s = ST_IF;
                    endcase
                end
                ST_MEM: begin
                    MEM_REQ = 1'b1;
                    IORD    = 1'b1;
                    REGRT   = dec_regrt_s;
                    WMEM    = (dec_class_s == CLS_SW);
                    if (MEM_READY) begin
                        state_next_s = (dec_class_s == CLS_LW) ? ST_WB : ST_IF;
                    end else begin
                        state_next_s = ST_MEM;
                    end
                end
                ST_WB: begin
                    WREG         = 1'b1;
                    REGRT        = dec_regrt_s;
                    M2REG        = (dec_class_s == CLS_LW);
                    state_next_s = ST_IF;
                end
                default: state_next_s = ST_IF;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic ret_evt_s;

    // A retire is any legal instruction whose last state hands back to IF.
    assign ret_evt_s = (state_r != ST_IF) && (state_next_s == ST_IF) && !ILLEGAL && !rst;

    // Free-running cycle and retire counters; both wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            CYC_CNT <= 32'd0;
            RET_CNT <= 32'd0;
        end else begin
            CYC_CNT <= CYC_CNT + 32'd1;
            if (ret_evt_s) begin
                RET_CNT <= RET_CNT + 32'd1;
            end else begin
                RET_CNT <= RET_CNT;
            end
        end
    end
`endif

endmodule
